// File: rtl/mips_pipeline_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control logic.
package mips_pipeline_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'b00,
    FWD_WRITEBACK = 2'b01,
    FWD_MEMORY    = 2'b10
  } forward_select_t;

  typedef enum logic [1:0] {
    MD_IDLE      = 2'b00,
    MD_MULT_BUSY = 2'b01,
    MD_DIV_BUSY  = 2'b10
  } multdiv_state_t;

  // True when a later stage writes a nonzero register that matches src.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return we && (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/multdiv_busy_tracker.sv
// Tracks an in-flight multi-cycle mult/div and reports when HI/LO is not yet valid.
module multdiv_busy_tracker
  import mips_pipeline_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned DIV_LATENCY  = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic start_multicycle,
  output logic busy
);

  localparam logic [5:0] MULT_LOAD = 6'(MULT_LATENCY - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LATENCY - 1);

  multdiv_state_t state;
  logic [5:0]     count;

  // An issuing op needs tracking only when its result takes more than one cycle.
  always_comb begin
    start_multicycle = 1'b0;
    if (start) begin
      start_multicycle = is_div ? (DIV_LATENCY > 1) : (MULT_LATENCY > 1);
    end
  end

  assign busy = (state != MD_IDLE);

  // Busy FSM: the edge on which the counter reaches zero returns to idle, so
  // busy covers latency-1 cycles and the issue cycle itself makes up the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start_multicycle) begin
            state <= is_div ? MD_DIV_BUSY : MD_MULT_BUSY;
            count <= is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        MD_MULT_BUSY, MD_DIV_BUSY: begin
          count <= count - 6'd1;
          if (count <= 6'd1) begin
            state <= MD_IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= MD_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stalls, bubble insertion and operand forwarding.
module hazard_controller
  import mips_pipeline_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned DIV_LATENCY  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs_decode,
  input  logic [4:0] rt_decode,
  input  logic [4:0] rs_execute,
  input  logic [4:0] rt_execute,
  input  logic [4:0] write_register_execute,
  input  logic [4:0] write_register_memory,
  input  logic [4:0] write_register_writeback,
  input  logic       register_write_execute,
  input  logic       register_write_memory,
  input  logic       register_write_writeback,
  input  logic       memory_to_register_execute,
  input  logic       memory_to_register_memory,
  input  logic       branch_decode,
  input  logic       multdiv_start_execute,
  input  logic       multdiv_is_div_execute,
  input  logic       hilo_read_decode,
  input  logic       multdiv_decode,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_execute,
  output logic [1:0] forward_a_execute,
  output logic [1:0] forward_b_execute,
  output logic       forward_a_decode,
  output logic       forward_b_decode,
  output logic       multdiv_busy
);

  forward_select_t fwd_a_ex, fwd_b_ex;
  logic start_multicycle;
  logic load_use_stall, branch_stall, multdiv_stall, stall;

  multdiv_busy_tracker #(
    .MULT_LATENCY(MULT_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_tracker (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (multdiv_start_execute),
    .is_div          (multdiv_is_div_execute),
    .start_multicycle(start_multicycle),
    .busy            (multdiv_busy)
  );

  // Execute-stage forwarding: memory stage wins over writeback.
  always_comb begin
    fwd_a_ex = FWD_REGFILE;
    fwd_b_ex = FWD_REGFILE;
    if (reg_match(rs_execute, write_register_memory, register_write_memory))
      fwd_a_ex = FWD_MEMORY;
    else if (reg_match(rs_execute, write_register_writeback, register_write_writeback))
      fwd_a_ex = FWD_WRITEBACK;
    if (reg_match(rt_execute, write_register_memory, register_write_memory))
      fwd_b_ex = FWD_MEMORY;
    else if (reg_match(rt_execute, write_register_writeback, register_write_writeback))
      fwd_b_ex = FWD_WRITEBACK;
  end

  assign forward_a_execute = fwd_a_ex;
  assign forward_b_execute = fwd_b_ex;
  assign forward_a_decode  = reg_match(rs_decode, write_register_memory, register_write_memory);
  assign forward_b_decode  = reg_match(rt_decode, write_register_memory, register_write_memory);

  // Stall causes are OR-ed so coincident hazards still cost a single bubble per cycle.
  always_comb begin
    load_use_stall = reg_match(rs_decode, write_register_execute, memory_to_register_execute) ||
                     reg_match(rt_decode, write_register_execute, memory_to_register_execute);
    branch_stall   = branch_decode &&
                     (reg_match(rs_decode, write_register_execute, register_write_execute) ||
                      reg_match(rt_decode, write_register_execute, register_write_execute) ||
                      reg_match(rs_decode, write_register_memory, memory_to_register_memory) ||
                      reg_match(rt_decode, write_register_memory, memory_to_register_memory));
    multdiv_stall  = (hilo_read_decode || multdiv_decode) && (multdiv_busy || start_multicycle);
    stall          = reset_n && (load_use_stall || branch_stall || multdiv_stall);
  end

  assign stall_fetch   = stall;
  assign stall_decode  = stall;
  assign flush_execute = stall;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute;
  logic [4:0] write_register_execute, write_register_memory, write_register_writeback;
  logic       register_write_execute, register_write_memory, register_write_writeback;
  logic       memory_to_register_execute, memory_to_register_memory;
  logic       branch_decode, multdiv_start_execute, multdiv_is_div_execute;
  logic       hilo_read_decode, multdiv_decode;
  logic       stall_fetch, stall_decode, flush_execute;
  logic [1:0] forward_a_execute, forward_b_execute;
  logic       forward_a_decode, forward_b_decode, multdiv_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .MULT_LATENCY(4),
    .DIV_LATENCY (32)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .rs_decode                 (rs_decode),
    .rt_decode                 (rt_decode),
    .rs_execute                (rs_execute),
    .rt_execute                (rt_execute),
    .write_register_execute    (write_register_execute),
    .write_register_memory     (write_register_memory),
    .write_register_writeback  (write_register_writeback),
    .register_write_execute    (register_write_execute),
    .register_write_memory     (register_write_memory),
    .register_write_writeback  (register_write_writeback),
    .memory_to_register_execute(memory_to_register_execute),
    .memory_to_register_memory (memory_to_register_memory),
    .branch_decode             (branch_decode),
    .multdiv_start_execute     (multdiv_start_execute),
    .multdiv_is_div_execute    (multdiv_is_div_execute),
    .hilo_read_decode          (hilo_read_decode),
    .multdiv_decode            (multdiv_decode),
    .stall_fetch               (stall_fetch),
    .stall_decode              (stall_decode),
    .flush_execute             (flush_execute),
    .forward_a_execute         (forward_a_execute),
    .forward_b_execute         (forward_b_execute),
    .forward_a_decode          (forward_a_decode),
    .forward_b_decode          (forward_b_decode),
    .multdiv_busy              (multdiv_busy)
  );

  // Clear all pipeline inputs to a neutral (no-hazard) pattern.
  task automatic clear_inputs();
    rs_decode = '0; rt_decode = '0; rs_execute = '0; rt_execute = '0;
    write_register_execute = '0; write_register_memory = '0; write_register_writeback = '0;
    register_write_execute = 1'b0; register_write_memory = 1'b0; register_write_writeback = 1'b0;
    memory_to_register_execute = 1'b0; memory_to_register_memory = 1'b0;
    branch_decode = 1'b0; multdiv_start_execute = 1'b0; multdiv_is_div_execute = 1'b0;
    hilo_read_decode = 1'b0; multdiv_decode = 1'b0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    memory_to_register_execute = 1'b1; write_register_execute = 5'd8; rs_decode = 5'd8;
    rs_execute = 5'd9; write_register_memory = 5'd9; register_write_memory = 1'b1;
    #4;
    n_cmp++;
    if ({stall_fetch, stall_decode, flush_execute} !== 3'b000) begin
      n_bad++; $display("FAIL reset_stall: got %b expected 000", {stall_fetch, stall_decode, flush_execute});
    end
    n_cmp++;
    if (multdiv_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", multdiv_busy);
    end
    n_cmp++;
    if (forward_a_execute !== 2'b10) begin
      n_bad++; $display("FAIL reset_fwd_comb: got %b expected 10", forward_a_execute);
    end
    next_cycle();
    reset_n = 1'b1;
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_load_use();
    // lw r8 in execute, add using r8 in decode
    clear_inputs();
    memory_to_register_execute = 1'b1; register_write_execute = 1'b1;
    write_register_execute = 5'd8; rs_decode = 5'd8; rt_decode = 5'd2;
    #4;
    n_cmp++;
    if ({stall_fetch, stall_decode, flush_execute} !== 3'b111) begin
      n_bad++; $display("FAIL load_use_stall: got %b expected 111", {stall_fetch, stall_decode, flush_execute});
    end
    // bubble in execute, lw in memory, add still in decode
    next_cycle();
    clear_inputs();
    memory_to_register_memory = 1'b1; register_write_memory = 1'b1;
    write_register_memory = 5'd8; rs_decode = 5'd8; rt_decode = 5'd2;
    #4;
    n_cmp++;
    if (stall_decode !== 1'b0) begin
      n_bad++; $display("FAIL load_use_release: got %b expected 0", stall_decode);
    end
    // add in execute, lw in writeback
    next_cycle();
    clear_inputs();
    register_write_writeback = 1'b1; write_register_writeback = 5'd8;
    rs_execute = 5'd8; rt_execute = 5'd2;
    #4;
    n_cmp++;
    if (forward_a_execute !== 2'b01) begin
      n_bad++; $display("FAIL load_use_fwd_wb: got %b expected 01", forward_a_execute);
    end
    // load-use through rt; then destination r0 must not stall
    next_cycle();
    clear_inputs();
    memory_to_register_execute = 1'b1; write_register_execute = 5'd12; rt_decode = 5'd12;
    #4;
    n_cmp++;
    if (stall_fetch !== 1'b1) begin
      n_bad++; $display("FAIL load_use_rt: got %b expected 1", stall_fetch);
    end
    write_register_execute = 5'd0; rt_decode = 5'd0; rs_decode = 5'd0;
    #1;
    n_cmp++;
    if (stall_fetch !== 1'b0) begin
      n_bad++; $display("FAIL load_use_r0: got %b expected 0", stall_fetch);
    end
    next_cycle();
  endtask

  task automatic test_exec_forward();
    clear_inputs();
    write_register_memory = 5'd9; write_register_writeback = 5'd9;
    register_write_memory = 1'b1; register_write_writeback = 1'b1;
    rs_execute = 5'd9; rt_execute = 5'd9;
    #4;
    n_cmp++;
    if (forward_a_execute !== 2'b10) begin
      n_bad++; $display("FAIL fwd_mem_priority: got %b expected 10", forward_a_execute);
    end
    n_cmp++;
    if (forward_b_execute !== 2'b10) begin
      n_bad++; $display("FAIL fwd_b_mem: got %b expected 10", forward_b_execute);
    end
    register_write_memory = 1'b0;
    #1;
    n_cmp++;
    if (forward_a_execute !== 2'b01) begin
      n_bad++; $display("FAIL fwd_wb: got %b expected 01", forward_a_execute);
    end
    register_write_memory = 1'b1;
    write_register_memory = 5'd0; write_register_writeback = 5'd0;
    rs_execute = 5'd0; rt_execute = 5'd0;
    #1;
    n_cmp++;
    if ({forward_a_execute, forward_b_execute} !== 4'b0000) begin
      n_bad++; $display("FAIL fwd_r0: got %b expected 0000", {forward_a_execute, forward_b_execute});
    end
    // rt matches memory, rs matches writeback only
    write_register_memory = 5'd4; write_register_writeback = 5'd5;
    rs_execute = 5'd5; rt_execute = 5'd4;
    #1;
    n_cmp++;
    if ({forward_a_execute, forward_b_execute} !== 4'b0110) begin
      n_bad++; $display("FAIL fwd_split: got %b expected 0110", {forward_a_execute, forward_b_execute});
    end
    next_cycle();
  endtask

  task automatic test_branch();
    // beq r3 in decode, ALU write to r3 in execute
    clear_inputs();
    branch_decode = 1'b1; rs_decode = 5'd3; rt_decode = 5'd7;
    register_write_execute = 1'b1; write_register_execute = 5'd3;
    #4;
    n_cmp++;
    if ({stall_fetch, stall_decode, flush_execute} !== 3'b111) begin
      n_bad++; $display("FAIL branch_stall: got %b expected 111", {stall_fetch, stall_decode, flush_execute});
    end
    // producer reaches memory: forward to comparator, no stall
    next_cycle();
    clear_inputs();
    branch_decode = 1'b1; rs_decode = 5'd3; rt_decode = 5'd7;
    register_write_memory = 1'b1; write_register_memory = 5'd3;
    #4;
    n_cmp++;
    if ({forward_a_decode, forward_b_decode, stall_decode} !== 3'b100) begin
      n_bad++; $display("FAIL branch_fwd: got %b expected 100", {forward_a_decode, forward_b_decode, stall_decode});
    end
    // load in memory feeding rt of branch still stalls
    memory_to_register_memory = 1'b1; write_register_memory = 5'd7;
    #1;
    n_cmp++;
    if ({stall_decode, forward_b_decode} !== 2'b11) begin
      n_bad++; $display("FAIL branch_load_mem: got %b expected 11", {stall_decode, forward_b_decode});
    end
    // same hazard without a branch in decode: no stall
    branch_decode = 1'b0;
    #1;
    n_cmp++;
    if (stall_decode !== 1'b0) begin
      n_bad++; $display("FAIL nobranch_nostall: got %b expected 0", stall_decode);
    end
    next_cycle();
  endtask

  task automatic test_div_mfhi();
    int stall_cycles = 0;
    int busy_cycles  = 0;
    int first_free   = -1;
    clear_inputs();
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b1; hilo_read_decode = 1'b1;
    #4;
    n_cmp++;
    if ({stall_decode, multdiv_busy} !== 2'b10) begin
      n_bad++; $display("FAIL div_issue: got %b expected 10", {stall_decode, multdiv_busy});
    end
    if (stall_decode === 1'b1) stall_cycles++;
    for (int i = 1; i <= 40; i++) begin
      next_cycle();
      multdiv_start_execute = 1'b0;
      #4;
      if (multdiv_busy === 1'b1) busy_cycles++;
      if (stall_decode === 1'b1) stall_cycles++;
      else if (first_free < 0) first_free = i;
    end
    n_cmp++;
    if (stall_cycles != 32) begin
      n_bad++; $display("FAIL div_stall_count: got %0d expected 32", stall_cycles);
    end
    n_cmp++;
    if (busy_cycles != 31) begin
      n_bad++; $display("FAIL div_busy_count: got %0d expected 31", busy_cycles);
    end
    n_cmp++;
    if (first_free != 32) begin
      n_bad++; $display("FAIL div_mfhi_proceeds: got cycle %0d expected 32", first_free);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_div();
    clear_inputs();
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      multdiv_start_execute = 1'b0;
      hilo_read_decode = 1'b1;
    end
    #1;
    n_cmp++;
    if ({multdiv_busy, stall_decode} !== 2'b11) begin
      n_bad++; $display("FAIL middiv_busy: got %b expected 11", {multdiv_busy, stall_decode});
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({multdiv_busy, stall_fetch, stall_decode, flush_execute} !== 4'b0000) begin
      n_bad++; $display("FAIL middiv_reset_abort: got %b expected 0000",
                        {multdiv_busy, stall_fetch, stall_decode, flush_execute});
    end
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    clear_inputs();
    hilo_read_decode = 1'b1;
    #4;
    n_cmp++;
    if ({multdiv_busy, stall_decode} !== 2'b00) begin
      n_bad++; $display("FAIL mflo_after_reset: got %b expected 00", {multdiv_busy, stall_decode});
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b0; multdiv_decode = 1'b1;
    #4;
    n_cmp++;
    if ({stall_decode, multdiv_busy} !== 2'b10) begin
      n_bad++; $display("FAIL mult2_issue_stall: got %b expected 10", {stall_decode, multdiv_busy});
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      multdiv_start_execute = 1'b0;
      #4;
      n_cmp++;
      if ({stall_decode, multdiv_busy} !== 2'b11) begin
        n_bad++; $display("FAIL mult2_busy_c%0d: got %b expected 11", i, {stall_decode, multdiv_busy});
      end
    end
    next_cycle();
    #4;
    n_cmp++;
    if ({stall_decode, multdiv_busy} !== 2'b00) begin
      n_bad++; $display("FAIL mult2_release: got %b expected 00", {stall_decode, multdiv_busy});
    end
    // second mult issues from execute
    next_cycle();
    multdiv_decode = 1'b0; multdiv_start_execute = 1'b1;
    #4;
    n_cmp++;
    if (multdiv_busy !== 1'b0) begin
      n_bad++; $display("FAIL mult2_start_idle: got %b expected 0", multdiv_busy);
    end
    next_cycle();
    multdiv_start_execute = 1'b0;
    #4;
    n_cmp++;
    if (multdiv_busy !== 1'b1) begin
      n_bad++; $display("FAIL mult2_busy_again: got %b expected 1", multdiv_busy);
    end
    // an unrelated instruction in decode is not held by a busy unit
    n_cmp++;
    if (stall_decode !== 1'b0) begin
      n_bad++; $display("FAIL mult_nonconsumer: got %b expected 0", stall_decode);
    end
    for (int i = 0; i < 4; i++) next_cycle();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #2;
    test_reset();
    test_load_use();
    test_exec_forward();
    test_branch();
    test_div_mfhi();
    test_reset_mid_div();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
